// File: rtl/seq_booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// Holds the FSM state encoding, the Booth op decode and the step-counter width.
package seq_booth_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } booth_op_t;

   // Radix-2 Booth recoding of the pair {Q[0], q_minus}.
   function automatic booth_op_t booth_decode(input logic q0, input logic q_minus);
      booth_op_t op;
      case ({q0, q_minus})
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

   // The counter has to reach WIDTH+1, the final step count.
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M_ext into acc,
// then an arithmetic shift right of {acc, Q, q_minus} by one bit.
module booth_step
   import seq_booth_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH+1:0] acc,
   input  logic [WIDTH:0]   q,
   input  logic             q_minus,
   input  logic [WIDTH:0]   m_ext,
   output logic [WIDTH+1:0] acc_next,
   output logic [WIDTH:0]   q_next,
   output logic             q_minus_next
);

   logic [WIDTH+1:0] m_wide;
   logic [WIDTH+1:0] sum;
   booth_op_t        op;

   // acc has one guard bit over M_ext so that subtracting the most-negative value cannot overflow.
   assign m_wide = {m_ext[WIDTH], m_ext};
   assign op     = booth_decode(q[0], q_minus);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      sum = acc;
      case (op)
         OP_ADD:  sum = acc + m_wide;
         OP_SUB:  sum = acc - m_wide;
         default: sum = acc;
      endcase
      {acc_next, q_next, q_minus_next} = {sum[WIDTH+1], sum, q};
   end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, one add/sub-and-shift step per clock.
// Handles signed or unsigned operands per operation; the product is held until the next done.
module seq_booth_multiplier
   import seq_booth_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   multiplicand,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int             CW        = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH);

   state_t             state_q,   state_d;
   logic [WIDTH+1:0]   acc_q,     acc_d;
   logic [WIDTH:0]     q_q,       q_d;
   logic               q_minus_q, q_minus_d;
   logic [WIDTH:0]     m_q,       m_d;
   logic [CW-1:0]      cnt_q,     cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [WIDTH+1:0]   acc_step;
   logic [WIDTH:0]     q_step;
   logic               q_minus_step;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc          (acc_q),
      .q            (q_q),
      .q_minus      (q_minus_q),
      .m_ext        (m_q),
      .acc_next     (acc_step),
      .q_next       (q_step),
      .q_minus_next (q_minus_step)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      q_d       = q_q;
      q_minus_d = q_minus_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               acc_d     = '0;
               q_d       = is_signed ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
               q_minus_d = 1'b0;
               m_d       = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
               cnt_d     = '0;
            end
         end
         ST_RUN: begin
            acc_d     = acc_step;
            q_d       = q_step;
            q_minus_d = q_minus_step;
            cnt_d     = cnt_q + 1'b1;
            // The last of the WIDTH+1 steps writes the product on the same edge.
            if (cnt_q == LAST_STEP) begin
               state_d   = ST_DONE;
               product_d = {acc_step[WIDTH-2:0], q_step};
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         q_q       <= '0;
         q_minus_q <= 1'b0;
         m_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q   <= state_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         q_minus_q <= q_minus_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed bench for seq_booth_multiplier: a WIDTH=4 instance for handshake, corner and reset
// behaviour, and a WIDTH=8 instance driven back-to-back with start held high.
module tb_seq_booth_multiplier;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start4 = 1'b0;
   logic       sgn4   = 1'b0;
   logic [3:0] mplr4  = '0;
   logic [3:0] mcnd4  = '0;
   logic       busy4;
   logic       done4;
   logic [7:0] prod4;

   logic        start8 = 1'b0;
   logic        sgn8   = 1'b0;
   logic [7:0]  mplr8  = '0;
   logic [7:0]  mcnd8  = '0;
   logic        busy8;
   logic        done8;
   logic [15:0] prod8;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] vals [10] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80,
                             8'h81, 8'hFF, 8'h55, 8'hAA, 8'hC3};

   always #5 clk = ~clk;

   seq_booth_multiplier #(.WIDTH(4)) u_dut4 (
      .clk          (clk),
      .rst          (rst),
      .start        (start4),
      .is_signed    (sgn4),
      .multiplier   (mplr4),
      .multiplicand (mcnd4),
      .busy         (busy4),
      .done         (done4),
      .product      (prod4)
   );

   seq_booth_multiplier #(.WIDTH(8)) u_dut8 (
      .clk          (clk),
      .rst          (rst),
      .start        (start8),
      .is_signed    (sgn8),
      .multiplier   (mplr8),
      .multiplicand (mcnd8),
      .busy         (busy8),
      .done         (done8),
      .product      (prod8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one request at the current time, waits for the accept edge, then drops start.
   task automatic issue4(input logic s, input logic [3:0] q, input logic [3:0] m);
      sgn4   = s;
      mplr4  = q;
      mcnd4  = m;
      start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
   endtask

   // Counts cycles after the accept edge until done; lat stays 0 on timeout.
   task automatic wait_done4(output logic [7:0] prod, output int lat, output int nbusy);
      lat   = 0;
      nbusy = 0;
      prod  = 8'hxx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (busy4) nbusy++;
         if (done4) begin
            lat  = k;
            prod = prod4;
            break;
         end
      end
   endtask

   task automatic op4(input string tag, input logic s, input logic [3:0] q, input logic [3:0] m,
                      input logic [7:0] exp);
      logic [7:0] p;
      int         lat;
      int         nb;
      @(negedge clk);
      issue4(s, q, m);
      wait_done4(p, lat, nb);
      check({tag, "_lat"}, lat, 6);
      check({tag, "_prod"}, p, exp);
   endtask

   function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
      int ia;
      int ib;
      int p;
      ia = s ? {{24{a[7]}}, a} : {24'b0, a};
      ib = s ? {{24{b[7]}}, b} : {24'b0, b};
      p  = ia * ib;
      return p[15:0];
   endfunction

   task automatic set_op8(input int i);
      sgn8  = (i >= 100);
      mplr8 = vals[(i % 100) / 10];
      mcnd8 = vals[i % 10];
   endtask

   initial begin
      logic [7:0]  p;
      logic [15:0] exp8;
      int          lat;
      int          nb;
      int          ndone;
      int          done_k;
      logic        early_bad;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_busy", busy4, 1'b0);
      check("rst_done", done4, 1'b0);
      check("rst_product", prod4, 8'h00);
      rst = 1'b0;

      // Signed 3 x -2: latency, busy span, product, single-cycle done
      @(negedge clk);
      issue4(1'b1, 4'd3, 4'hE);
      wait_done4(p, lat, nb);
      check("s3xm2_lat", lat, 6);
      check("s3xm2_busy_cycles", nb, 5);
      check("s3xm2_prod", p, 8'hFA);
      @(negedge clk);
      check("s3xm2_done_pulse", done4, 1'b0);
      check("s3xm2_hold", prod4, 8'hFA);

      // Signed corners
      op4("s_m8xm8", 1'b1, 4'h8, 4'h8, 8'h40);
      op4("s_m8x7",  1'b1, 4'h8, 4'h7, 8'hC8);
      op4("s_0xm8",  1'b1, 4'h0, 4'h8, 8'h00);

      // Unsigned, then the same bit patterns signed
      op4("u_15x15", 1'b0, 4'hF, 4'hF, 8'hE1);
      op4("u_8x8",   1'b0, 4'h8, 4'h8, 8'h40);
      op4("s_Fx F",  1'b1, 4'hF, 4'hF, 8'h01);
      op4("s_8x8",   1'b1, 4'h8, 4'h8, 8'h40);

      // Second start during RUN is ignored; previous product holds until the done
      @(negedge clk);
      issue4(1'b1, 4'd3, 4'd3);
      ndone     = 0;
      done_k    = 0;
      early_bad = 1'b0;
      p         = 8'hxx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (done4) begin
            ndone++;
            if (ndone == 1) begin
               done_k = k;
               p      = prod4;
            end
         end else if (ndone == 0 && prod4 !== 8'h40) begin
            early_bad = 1'b1;
         end
         if (k == 2) begin
            sgn4   = 1'b1;
            mplr4  = 4'd2;
            mcnd4  = 4'd2;
            start4 = 1'b1;
         end
      end
      check("ign_done_count", ndone, 1);
      check("ign_lat", done_k, 6);
      check("ign_prod", p, 8'h09);
      check("ign_prior_stable", early_bad, 1'b0);

      // Reset two cycles into RUN clears everything at once
      @(negedge clk);
      issue4(1'b0, 4'd7, 4'd7);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_busy", busy4, 1'b0);
      check("abort_done", done4, 1'b0);
      check("abort_product", prod4, 8'h00);
      @(negedge clk);
      check("abort_held_done", done4, 1'b0);

      // Start raised together with reset release is taken on the first edge after
      @(negedge clk);
      rst = 1'b0;
      issue4(1'b0, 4'd5, 4'd5);
      wait_done4(p, lat, nb);
      check("post_rst_lat", lat, 6);
      check("post_rst_prod", p, 8'h19);

      // WIDTH=8 back-to-back run with start held high: results and one per 11 cycles
      @(negedge clk);
      set_op8(0);
      start8 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         lat  = 0;
         exp8 = ref8(sgn8, mplr8, mcnd8);
         for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done8) begin
               lat = k;
               break;
            end
         end
         check((i == 0) ? "w8_first_lat" : "w8_period", lat, (i == 0) ? 10 : 11);
         check("w8_prod", prod8, exp8);
         if (i < 199) set_op8(i + 1);
         else start8 = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
